melody_player: RTL
==================

# melody_player

Upstream stage of `sound_gen`: plays one of four fixed melodies from an internal note ROM and drives `sound_gen`'s 10-bit `freq` input, with `freq = 0` meaning silence. Game logic issues a one-cycle `start` with a melody index. The block then steps through the notes, timing each note in milliseconds from the shared `ticks_per_milli` value, and pulses `done` when the melody finishes.

## Interface
- `GAP_MS`, default 20: length of the silent gap between consecutive notes, in ms (only used with `MELODY_GAP_EN`).
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous reset, active-low.
- `ticks_per_milli` in 6: clock cycles per millisecond; the same value that feeds `sound_gen`.
- `start` in 1: one-cycle request to begin playing `melody`.
- `melody` in 2: melody index; sampled only in the cycle where `start` is high.
- `stop` in 1: abort playback.
- `freq` out 10: tone in Hz for `sound_gen`; 0 = silent. Registered.
- `busy` out 1: high while a melody is playing, including gaps.
- `done` out 1: one-cycle pulse when a melody completes normally.

## Operation
- **ROM** (freq Hz / duration ms, in order):
  - Melody 0: 262/100, 330/100, 392/200.
  - Melody 1: 392/100, 523/100, 659/100, 784/300.
  - Melody 2: 196/300, 147/500.
  - Melody 3: 440/50.
- **ROM format:** each entry is 10-bit freq, 10-bit duration and a last flag. Entries sit at index `{melody, note[2:0]}`, so each melody can hold up to 8 notes.
- **FSM states:** IDLE, NOTE, GAP (GAP exists only with `MELODY_GAP_EN`).
- **IDLE + `start`:**
  - Latch `melody`, set note index to 0.
  - Load the ROM entry, clear the ms prescaler and ms counter, go to NOTE.
- **NOTE:**
  - `freq` = entry freq.
  - When the ms count reaches the entry duration:
    - If the last flag is set: go to IDLE, drive `freq = 0`, pulse `done`.
    - Otherwise: go to GAP (if enabled) or directly to the next note.
- **GAP:** `freq = 0` for `GAP_MS` ms, then load the next note and go to NOTE.
- **ms prescaler:**
  - Counts 0..`ticks_per_milli`−1; the wrap cycle is one ms tick.
  - The wrap comparison uses `>=`, so a change to `ticks_per_milli` takes effect immediately without overrun.
  - `ticks_per_milli = 0` is treated as 1.
- **Retrigger:** `start` while busy restarts immediately with the newly sampled melody, from note 0 with the counters cleared. No `done` is produced for the aborted melody.
- **`stop`:** in any state, go to IDLE with `freq = 0` and `busy = 0` on the next cycle; no `done`. If `stop` and `start` occur in the same cycle, `stop` wins.
- **Arithmetic:** ms counter is 10 bits; prescaler is 6 bits. The duration in ms is never 0 in the ROM.

## Timing
- **Reset** (`rst_n` low at a clock edge): `freq = 0`, `busy = 0`, `done = 0`, state = IDLE, all counters cleared. Reset mid-melody silences the output on the next cycle.
- **Start latency:** `start` sampled at edge N gives `freq` = first note and `busy = 1` from edge N+1.
- **Note length:** each note drives `freq` for exactly duration × `ticks_per_milli` cycles. Between notes without a gap, the next note's freq appears on the cycle immediately after; there are no zero cycles.
- **Gap length:** exactly `GAP_MS` × `ticks_per_milli` cycles of `freq = 0`.
- **End of melody:** `done` is high for exactly one cycle, coincident with the first cycle of `freq = 0` and `busy = 0`.
- **Back-to-back:** `start` in the same cycle as `done` is accepted, because the FSM is in IDLE logic at that decision point. The new first note appears on the next cycle.

## Configuration
- **`MELODY_GAP_EN` defined:** the GAP state is present and a `GAP_MS` silence is inserted between consecutive notes of a melody. There is no gap after the last note.
- **`MELODY_GAP_EN` undefined:** the GAP state is removed, notes play back-to-back, and `GAP_MS` is ignored.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with `start` = 1 → `freq = 0`, `busy = 0`, `done = 0` throughout.
- **Melody 3:** `ticks_per_milli = 4`, `start` with melody 3 → `freq = 440` for exactly 200 cycles starting the cycle after `start`. Then a 1-cycle `done` pulse with `freq = 0` and `busy = 0`.
- **Melody 0, no gap:** `ticks_per_milli = 2` → 262 for 200 cycles, 330 for 200, 392 for 400, then `done`.
- **Melody 0, `MELODY_GAP_EN`** (`GAP_MS = 20`, `ticks_per_milli = 2`) → 40 zero cycles between each pair of notes, total `busy` = 880 cycles.
- **Abort:** `stop` during the 2nd note of melody 1 → `freq = 0` and `busy = 0` the next cycle, no `done`.
- **Retrigger:** `start` with melody 2 during melody 1 → `freq = 196` the next cycle, for the full 300 ms. `done` fires only after 147 Hz has played 500 ms.

Source files
------------

// File: rtl/melody_player.sv
// ============================================================================
// Module      : melody_player
// Description : Plays one of four fixed melodies from an internal note ROM
//               and drives the 10-bit tone frequency of sound_gen (0 = silent).
//               Note timing is counted in milliseconds derived from the shared
//               ticks_per_milli value. Pulses done when a melody completes.
//               Optional feature macro: MELODY_GAP_EN inserts a GAP_MS silence
//               between consecutive notes of a melody.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module melody_player #(
    parameter int GAP_MS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] ticks_per_milli,
    input  logic       start,
    input  logic [1:0] melody,
    input  logic       stop,
    output logic [9:0] freq,
    output logic       busy,
    output logic       done
);

`ifdef MELODY_GAP_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NOTE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Last ms index of the inter-note gap; a gap of 0 ms is clamped to 1 ms.
    localparam logic [9:0] c_GAP_LAST = (GAP_MS > 1) ? 10'(GAP_MS - 1) : 10'd0;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_NOTE = 1'b1
    } state_t;

    // Gap length has no effect when gaps are compiled out.
    if (GAP_MS < 0) begin : g_gap_ms_ignored
    end
`endif

    // ROM entry layout: {last, freq[9:0], duration_ms[9:0]} at {melody, note}.
    function automatic logic [20:0] rom_entry(input logic [4:0] idx);
        logic [20:0] e;
        case (idx)
            5'd0:    e = {1'b0, 10'd262, 10'd100};
            5'd1:    e = {1'b0, 10'd330, 10'd100};
            5'd2:    e = {1'b1, 10'd392, 10'd200};
            5'd8:    e = {1'b0, 10'd392, 10'd100};
            5'd9:    e = {1'b0, 10'd523, 10'd100};
            5'd10:   e = {1'b0, 10'd659, 10'd100};
            5'd11:   e = {1'b1, 10'd784, 10'd300};
            5'd16:   e = {1'b0, 10'd196, 10'd300};
            5'd17:   e = {1'b1, 10'd147, 10'd500};
            5'd24:   e = {1'b1, 10'd440, 10'd50};
            // Unused slots terminate silently after 1 ms.
            default: e = {1'b1, 10'd0, 10'd1};
        endcase
        return e;
    endfunction

    state_t      r_state;
    logic [1:0]  r_melody;
    logic [2:0]  r_note;
    logic [9:0]  r_dur;
    logic        r_last;
    logic [5:0]  r_presc;
    logic [9:0]  r_ms;

    state_t      w_state_nxt;
    logic [1:0]  w_melody_nxt;
    logic [2:0]  w_note_nxt;
    logic [9:0]  w_dur_nxt;
    logic        w_last_nxt;
    logic [5:0]  w_presc_nxt;
    logic [9:0]  w_ms_nxt;
    logic [9:0]  w_freq_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;

    logic [5:0]  w_tpm_last;
    logic        w_tick;
    logic [2:0]  w_note_inc;
    logic [4:0]  w_load_idx;
    logic [20:0] w_load_entry;

    // A zero ticks_per_milli behaves as 1; '>=' makes a lowered rate wrap at once.
    assign w_tpm_last = (ticks_per_milli == 6'd0) ? 6'd0 : ticks_per_milli - 6'd1;
    assign w_tick     = (r_presc >= w_tpm_last);

    // One ROM read serves both a fresh start and advancing to the next note.
    assign w_note_inc   = r_note + 3'd1;
    assign w_load_idx   = start ? {melody, 3'd0} : {r_melody, w_note_inc};
    assign w_load_entry = rom_entry(w_load_idx);

    // Next-state and registered-output decode; stop beats start, start beats playback.
    always_comb begin
        w_state_nxt  = r_state;
        w_melody_nxt = r_melody;
        w_note_nxt   = r_note;
        w_dur_nxt    = r_dur;
        w_last_nxt   = r_last;
        w_presc_nxt  = w_tick ? 6'd0 : r_presc + 6'd1;
        w_ms_nxt     = w_tick ? r_ms + 10'd1 : r_ms;
        w_freq_nxt   = freq;
        w_busy_nxt   = busy;
        w_done_nxt   = 1'b0;

        if (stop) begin
            w_state_nxt = S_IDLE;
            w_presc_nxt = 6'd0;
            w_ms_nxt    = 10'd0;
            w_freq_nxt  = 10'd0;
            w_busy_nxt  = 1'b0;
        end else if (start) begin
            w_state_nxt  = S_NOTE;
            w_melody_nxt = melody;
            w_note_nxt   = 3'd0;
            w_last_nxt   = w_load_entry[20];
            w_freq_nxt   = w_load_entry[19:10];
            w_dur_nxt    = w_load_entry[9:0];
            w_presc_nxt  = 6'd0;
            w_ms_nxt     = 10'd0;
            w_busy_nxt   = 1'b1;
        end else begin
            case (r_state)
                S_NOTE: begin
                    // Final tick of the last ms of this note.
                    if (w_tick && (r_ms == r_dur - 10'd1)) begin
                        w_presc_nxt = 6'd0;
                        w_ms_nxt    = 10'd0;
                        if (r_last) begin
                            w_state_nxt = S_IDLE;
                            w_freq_nxt  = 10'd0;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
`ifdef MELODY_GAP_EN
                            w_state_nxt = S_GAP;
                            w_freq_nxt  = 10'd0;
`else
                            w_note_nxt  = w_note_inc;
                            w_last_nxt  = w_load_entry[20];
                            w_freq_nxt  = w_load_entry[19:10];
                            w_dur_nxt   = w_load_entry[9:0];
`endif
                        end
                    end
                end
`ifdef MELODY_GAP_EN
                S_GAP: begin
                    if (w_tick && (r_ms == c_GAP_LAST)) begin
                        w_state_nxt = S_NOTE;
                        w_note_nxt  = w_note_inc;
                        w_last_nxt  = w_load_entry[20];
                        w_freq_nxt  = w_load_entry[19:10];
                        w_dur_nxt   = w_load_entry[9:0];
                        w_presc_nxt = 6'd0;
                        w_ms_nxt    = 10'd0;
                    end
                end
`endif
                default: begin
                    w_state_nxt = S_IDLE;
                    w_presc_nxt = 6'd0;
                    w_ms_nxt    = 10'd0;
                    w_freq_nxt  = 10'd0;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // State, counters and outputs registered with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_melody <= 2'd0;
            r_note   <= 3'd0;
            r_dur    <= 10'd0;
            r_last   <= 1'b0;
            r_presc  <= 6'd0;
            r_ms     <= 10'd0;
            freq     <= 10'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_melody <= w_melody_nxt;
            r_note   <= w_note_nxt;
            r_dur    <= w_dur_nxt;
            r_last   <= w_last_nxt;
            r_presc  <= w_presc_nxt;
            r_ms     <= w_ms_nxt;
            freq     <= w_freq_nxt;
            busy     <= w_busy_nxt;
            done     <= w_done_nxt;
        end
    end

endmodule

`default_nettype wire
